// File: rtl/jump_redirect_ctrl.sv
// Jump redirect controller: sequences JAL/JALR from decode through the rs1 hazard
// wait, the PC redirect handshake, the wrong-path flush and misaligned-target exceptions.
//
// state    | meaning
// IDLE     | watching ID for a jump
// WAIT_RS1 | JALR held in ID until its rs1 write lands
// REDIRECT | target captured, redirect request held until ack
// EXC      | one-cycle misaligned-target exception pulse
// FLUSH    | squashing wrong-path fetch for FLUSH_CYCLES cycles
module jump_redirect_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_id_valid,
  input  logic [31:0]     i_id_instrn,
  input  logic [XLEN-1:0] i_id_pc,
  input  logic [XLEN-1:0] i_jt_target,
  input  logic            i_rs1_busy,
  output logic            o_id_stall,
  output logic            o_redirect_valid,
  output logic [XLEN-1:0] o_redirect_pc,
  input  logic            i_redirect_ack,
  output logic            o_if_flush,
  output logic            o_link_valid,
  output logic [XLEN-1:0] o_link_data,
  output logic            o_misalign_exc,
  output logic [XLEN-1:0] o_exc_tval
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RS1 = 3'd1,
    S_REDIRECT = 3'd2,
    S_EXC      = 3'd3,
    S_FLUSH    = 3'd4
  } state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_redirect_valid;
  logic            r_if_flush;
  logic            r_misalign_exc;
  logic [XLEN-1:0] r_redirect_pc;
  logic [XLEN-1:0] r_link_data;
  logic [XLEN-1:0] r_exc_tval;

  logic            w_is_jal;
  logic            w_is_jalr;
  logic            w_is_jump;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_link;
  logic            w_misalign;
  logic            w_capture;
  logic            w_id_stall;
  logic            w_unused;

  assign w_is_jal   = (i_id_instrn[6:0] == 7'b1101111);
  assign w_is_jalr  = (i_id_instrn[6:0] == 7'b1100111) && (i_id_instrn[14:12] == 3'b000);
  assign w_is_jump  = w_is_jal | w_is_jalr;
  assign w_target   = w_is_jalr ? {i_jt_target[XLEN-1:1], 1'b0} : i_jt_target;
  assign w_link     = i_id_pc + XLEN'(4);
  assign w_misalign = w_target[1];
  assign w_unused   = ^{i_id_instrn[31:15], i_id_instrn[11:7]};

  // A JALR with a pending rs1 defers capture to the cycle the scoreboard releases it.
  assign w_capture = ((r_state == S_IDLE) && i_id_valid && w_is_jump && !(w_is_jalr && i_rs1_busy))
                   || ((r_state == S_WAIT_RS1) && i_id_valid && !i_rs1_busy);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_redirect_valid <= 1'b0;
      r_if_flush       <= 1'b0;
      r_misalign_exc   <= 1'b0;
      r_redirect_pc    <= '0;
      r_link_data      <= '0;
      r_exc_tval       <= '0;
    end else if (w_capture) begin
      r_redirect_pc    <= w_target;
      r_link_data      <= w_link;
      r_exc_tval       <= w_target;
      r_redirect_valid <= ~w_misalign;
      r_misalign_exc   <= w_misalign;
      r_state          <= w_misalign ? S_EXC : S_REDIRECT;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_id_valid && w_is_jump) r_state <= S_WAIT_RS1;
        end
        S_WAIT_RS1: begin
          if (!i_id_valid) r_state <= S_IDLE;
        end
        S_REDIRECT: begin
          if (i_redirect_ack) begin
            r_redirect_valid <= 1'b0;
            r_if_flush       <= 1'b1;
            r_cnt            <= FLUSH_INIT;
            r_state          <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (r_cnt <= 4'd1) begin
            r_cnt      <= '0;
            r_if_flush <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_EXC: begin
          r_misalign_exc <= 1'b0;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_id_stall = 1'b0;
    unique case (r_state)
      S_IDLE:     w_id_stall = i_id_valid & w_is_jump;
      S_WAIT_RS1: w_id_stall = 1'b1;
      S_REDIRECT: w_id_stall = ~i_redirect_ack;
      default:    w_id_stall = 1'b0;
    endcase
  end

  // Reset overrides a same-cycle ack so a dropped redirect never writes rd.
  assign o_id_stall       = w_id_stall & ~i_rst;
  assign o_link_valid     = (r_state == S_REDIRECT) & i_redirect_ack & ~i_rst;
  assign o_redirect_valid = r_redirect_valid;
  assign o_redirect_pc    = r_redirect_pc;
  assign o_if_flush       = r_if_flush;
  assign o_link_data      = r_link_data;
  assign o_misalign_exc   = r_misalign_exc;
  assign o_exc_tval       = r_exc_tval;

endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// Directed bench for jump_redirect_ctrl: per-cycle vector table against a FLUSH_CYCLES=1
// instance, plus a hand sequence checking flush-time squash on a FLUSH_CYCLES=3 instance.
module tb_jump_redirect_ctrl;

  localparam logic [31:0] JAL   = 32'h0000_006F;
  localparam logic [31:0] JALR  = 32'h0000_0067;
  localparam logic [31:0] JALR1 = 32'h0000_1067;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, id_valid, rs1_busy, ack;
  logic [31:0] instrn, pc, tgt;

  logic        stall, rv, fl, lv, me;
  logic [31:0] rpc, ld, tv;
  logic        s3, rv3, fl3, lv3, me3;
  logic [31:0] rpc3, ld3, tv3;

  int n_checks = 0;
  int n_fail   = 0;

  jump_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .i_id_instrn(instrn),
    .i_id_pc(pc), .i_jt_target(tgt), .i_rs1_busy(rs1_busy),
    .o_id_stall(stall), .o_redirect_valid(rv), .o_redirect_pc(rpc),
    .i_redirect_ack(ack), .o_if_flush(fl), .o_link_valid(lv),
    .o_link_data(ld), .o_misalign_exc(me), .o_exc_tval(tv)
  );

  jump_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .i_id_instrn(instrn),
    .i_id_pc(pc), .i_jt_target(tgt), .i_rs1_busy(rs1_busy),
    .o_id_stall(s3), .o_redirect_valid(rv3), .o_redirect_pc(rpc3),
    .i_redirect_ack(ack), .o_if_flush(fl3), .o_link_valid(lv3),
    .o_link_data(ld3), .o_misalign_exc(me3), .o_exc_tval(tv3)
  );

  typedef struct {
    logic        rst, v;
    logic [31:0] ins, pc, tgt;
    logic        busy, ack;
    logic        stall, rv;
    logic [31:0] rpc;
    logic        fl, lv;
    logic [31:0] ld;
    logic        me;
    logic [31:0] tv;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic r, v, input logic [31:0] ins, p, t, input logic b, a,
    input logic e_st, e_rv, input logic [31:0] e_rpc, input logic e_fl, e_lv,
    input logic [31:0] e_ld, input logic e_me, input logic [31:0] e_tv);
    vec_t x;
    x.rst = r; x.v = v; x.ins = ins; x.pc = p; x.tgt = t; x.busy = b; x.ack = a;
    x.stall = e_st; x.rv = e_rv; x.rpc = e_rpc; x.fl = e_fl; x.lv = e_lv;
    x.ld = e_ld; x.me = e_me; x.tv = e_tv;
    return x;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, v, input logic [31:0] ins, p, t, input logic b, a);
    @(negedge clk);
    rst = r; id_valid = v; instrn = ins; pc = p; tgt = t; rs1_busy = b; ack = a;
    #1;
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; instrn = NOP; pc = '0; tgt = '0; rs1_busy = 1'b0; ack = 1'b0;

    // JAL, ack in first REDIRECT cycle, then back-to-back JALR with rs1 hazard
    tbl.push_back(mk(0,1,JAL ,32'h100,32'h200 ,0,0, 1,0,32'h200 ,0,0,32'h104 ,0,32'h200 ));
    tbl[0].rpc = 32'h0; tbl[0].ld = 32'h0; tbl[0].tv = 32'h0;
    tbl.push_back(mk(0,1,JAL ,32'h100,32'h200 ,0,1, 0,1,32'h200 ,0,1,32'h104 ,0,32'h200 ));
    tbl.push_back(mk(0,0,NOP ,32'h0  ,32'h0   ,0,0, 0,0,32'h200 ,1,0,32'h104 ,0,32'h200 ));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,1,JALR,32'h2000,32'h1111,1,0, 1,0,32'h200,0,0,32'h104,0,32'h200));
    tbl.push_back(mk(0,1,JALR,32'h2000,32'h3001,0,0, 1,0,32'h200 ,0,0,32'h104 ,0,32'h200 ));
    // ack withheld 5 cycles; ID contents change underneath
    tbl.push_back(mk(0,1,JALR,32'h2000,32'h3001,0,0, 1,1,32'h3000,0,0,32'h2004,0,32'h3000));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,NOP,32'h0,32'hDEAD0000,0,0, 1,1,32'h3000,0,0,32'h2004,0,32'h3000));
    tbl.push_back(mk(0,0,NOP ,32'h0  ,32'hDEAD0000,0,1, 0,1,32'h3000,0,1,32'h2004,0,32'h3000));
    tbl.push_back(mk(0,0,NOP ,32'h0  ,32'h0   ,0,0, 0,0,32'h3000,1,0,32'h2004,0,32'h3000));
    // misaligned JAL
    tbl.push_back(mk(0,1,JAL ,32'h400,32'h402 ,0,0, 1,0,32'h3000,0,0,32'h2004,0,32'h3000));
    tbl.push_back(mk(0,1,JAL ,32'h400,32'h402 ,0,1, 0,0,32'h402 ,0,0,32'h404 ,1,32'h402 ));
    tbl.push_back(mk(0,0,NOP ,32'h0  ,32'h0   ,0,0, 0,0,32'h402 ,0,0,32'h404 ,0,32'h402 ));
    // abort from WAIT_RS1
    tbl.push_back(mk(0,1,JALR,32'h500,32'h600 ,1,0, 1,0,32'h402 ,0,0,32'h404 ,0,32'h402 ));
    tbl.push_back(mk(0,0,JALR,32'h500,32'h600 ,1,0, 1,0,32'h402 ,0,0,32'h404 ,0,32'h402 ));
    tbl.push_back(mk(0,0,NOP ,32'h0  ,32'h0   ,0,0, 0,0,32'h402 ,0,0,32'h404 ,0,32'h402 ));
    // non-jumps ignored
    tbl.push_back(mk(0,1,JALR1,32'h700,32'h800,0,0, 0,0,32'h402 ,0,0,32'h404 ,0,32'h402 ));
    tbl.push_back(mk(0,1,NOP ,32'h700,32'h800 ,0,0, 0,0,32'h402 ,0,0,32'h404 ,0,32'h402 ));
    tbl.push_back(mk(0,1,JALR1,32'h700,32'h800,1,0, 0,0,32'h402 ,0,0,32'h404 ,0,32'h402 ));
    // link wrap
    tbl.push_back(mk(0,1,JAL ,32'hFFFFFFFC,32'h10,0,0, 1,0,32'h402,0,0,32'h404,0,32'h402));
    tbl.push_back(mk(0,1,JAL ,32'hFFFFFFFC,32'h10,0,1, 0,1,32'h10 ,0,1,32'h0  ,0,32'h10 ));
    tbl.push_back(mk(0,0,NOP ,32'h0  ,32'h0   ,0,0, 0,0,32'h10  ,1,0,32'h0   ,0,32'h10  ));
    // JALR bit0 cleared, then reset together with ack in REDIRECT
    tbl.push_back(mk(0,1,JALR,32'h80 ,32'h905 ,0,0, 1,0,32'h10  ,0,0,32'h0   ,0,32'h10  ));
    tbl.push_back(mk(0,0,NOP ,32'h0  ,32'h0   ,0,0, 1,1,32'h904 ,0,0,32'h84  ,0,32'h904 ));
    tbl.push_back(mk(1,0,NOP ,32'h0  ,32'h0   ,0,1, 0,1,32'h904 ,0,0,32'h84  ,0,32'h904 ));
    tbl.push_back(mk(0,0,NOP ,32'h0  ,32'h0   ,0,1, 0,0,32'h0   ,0,0,32'h0   ,0,32'h0   ));
    tbl.push_back(mk(0,0,NOP ,32'h0  ,32'h0   ,0,0, 0,0,32'h0   ,0,0,32'h0   ,0,32'h0   ));

    drive(1,0,NOP,32'h0,32'h0,0,0);
    drive(1,0,NOP,32'h0,32'h0,0,0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].ins, tbl[i].pc, tbl[i].tgt, tbl[i].busy, tbl[i].ack);
      chk("id_stall",       i, {31'b0, stall}, {31'b0, tbl[i].stall});
      chk("redirect_valid", i, {31'b0, rv},    {31'b0, tbl[i].rv});
      chk("redirect_pc",    i, rpc,            tbl[i].rpc);
      chk("if_flush",       i, {31'b0, fl},    {31'b0, tbl[i].fl});
      chk("link_valid",     i, {31'b0, lv},    {31'b0, tbl[i].lv});
      chk("link_data",      i, ld,             tbl[i].ld);
      chk("misalign_exc",   i, {31'b0, me},    {31'b0, tbl[i].me});
      chk("exc_tval",       i, tv,             tbl[i].tv);
    end

    // FLUSH_CYCLES=3: a jump sitting in ID during flush must be squashed
    drive(0,1,JAL,32'h100,32'h200,0,0);
    chk("f3_stall_detect", 0, {31'b0, s3}, 32'd1);
    drive(0,1,JAL,32'h100,32'h200,0,1);
    chk("f3_redirect_valid", 1, {31'b0, rv3}, 32'd1);
    chk("f3_link_valid",     1, {31'b0, lv3}, 32'd1);
    chk("f3_redirect_pc",    1, rpc3, 32'h200);
    for (int c = 2; c <= 4; c++) begin
      drive(0,1,JAL,32'h900,32'hA00,0,0);
      chk("f3_if_flush",       c, {31'b0, fl3}, 32'd1);
      chk("f3_stall_in_flush", c, {31'b0, s3},  32'd0);
      chk("f3_no_redirect",    c, {31'b0, rv3}, 32'd0);
    end
    drive(0,0,NOP,32'h0,32'h0,0,0);
    chk("f3_flush_end",   5, {31'b0, fl3}, 32'd0);
    chk("f3_no_redirect", 5, {31'b0, rv3}, 32'd0);
    chk("f3_pc_kept",     5, rpc3, 32'h200);
    drive(0,0,NOP,32'h0,32'h0,0,0);
    chk("f3_no_redirect", 6, {31'b0, rv3}, 32'd0);
    chk("f3_no_exc",      6, {31'b0, me3}, 32'd0);
    chk("f3_link_kept",   6, ld3, 32'h104);
    chk("f3_tval_kept",   6, tv3, 32'h200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
